pixel_raw10_packer: RTL

Packs the 4-pixel, 10-bit-per-pixel AXI4-Stream produced by the pixel reorder stage into the MIPI CSI-2 RAW10 byte format (4 pixels → 5 bytes) on a 32-bit output stream. It sits directly downstream of the pixel swap stage and feeds the CSI-2 packet builder / D-PHY TX. It is a 40→32-bit gearbox with an 8-byte residue buffer and per-line flush with zero padding.

---
 rtl/pixel_raw10_packer_if.sv | 27 ++
 rtl/pixel_raw10_packer.sv | 109 ++++++++++
 2 files changed

// File: rtl/pixel_raw10_packer_if.sv
// AXI4-Stream style bundle shared by the packer's input and output sides.
//   tdata  : payload, DATA_BITS wide
//   tuser  : sideband, bit 0 marks frame start
//   tlast  : last beat of a line
//   tvalid : source has a beat
//   tready : sink accepts the beat
// master drives payload/valid and samples ready; slave is the mirror image.
interface pixel_raw10_packer_if #(
    parameter int DATA_BITS = 32,
    parameter int USER_BITS = 1
);
    logic [DATA_BITS-1:0] tdata;
    logic [USER_BITS-1:0] tuser;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (
        output tdata, tuser, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/pixel_raw10_packer.sv
// RAW10 packer: turns 4 x 10-bit pixel beats (40 bits) into the MIPI CSI-2
// RAW10 byte order (4 pixels -> 5 bytes) on a 32-bit stream. The 40->32
// gearbox keeps up to 8 bytes of residue; at each line end the residue is
// flushed, the final beat padded with 0x00, and lines never share a beat.
//   clk    : stream clock, rising edge
//   reset  : synchronous, active-high
//   s      : input stream (40-bit tdata, pixel i at [10i+9:10i])
//   m      : output stream (32-bit tdata, earliest byte in [7:0])
module pixel_raw10_packer #(
    parameter int USER_BITS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_raw10_packer_if.slave   s,
    pixel_raw10_packer_if.master  m
);

    // Residue buffer, byte 0 is the oldest. Bytes at or above cnt_reg are
    // always held at zero, so the low word is already correctly padded.
    logic [63:0]          buf_reg, buf_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic                 flush_reg, flush_next;
    logic                 first_reg, first_next;
    logic [USER_BITS-1:0] user_reg, user_next;

    logic [39:0] in_bytes;
    logic        m_valid, m_last, m_fire;
    logic        s_ready, s_fire;
    logic [3:0]  consume;
    logic [3:0]  base;

    // Bytes 0..3 carry the pixel MSBs; byte 4 gathers the four 2-bit LSB
    // fields with P0 in the lowest bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_map
            assign in_bytes[8*gi +: 8]      = s.tdata[10*gi+2 +: 8];
            assign in_bytes[32+2*gi +: 2]   = s.tdata[10*gi +: 2];
        end
    endgenerate

    assign m_valid = (cnt_reg >= 4'd4) || (flush_reg && (cnt_reg != 4'd0));
    assign m_last  = flush_reg && (cnt_reg <= 4'd4);
    assign m_fire  = m_valid && m.tready;

    // Accepting while an output beat leaves keeps full throughput; this is
    // a deliberate combinational m.tready -> s.tready path.
    assign s_ready = !flush_reg &&
                     ((cnt_reg <= 4'd3) || (m_fire && (cnt_reg <= 4'd7)));
    assign s_fire  = s.tvalid && s_ready;

    assign consume = !m_fire            ? 4'd0 :
                     (cnt_reg >= 4'd4)  ? 4'd4 : cnt_reg;
    // Insert position for new bytes; at most 3 whenever s_fire is true.
    assign base    = cnt_reg - consume;

    assign s.tready = s_ready;
    assign m.tvalid = m_valid;
    assign m.tlast  = m_valid && m_last;
    assign m.tdata  = buf_reg[31:0];
    assign m.tuser  = (m_valid && first_reg) ? user_reg : '0;

    always_comb begin
        buf_next   = buf_reg >> {consume, 3'b000};
        cnt_next   = cnt_reg - consume + (s_fire ? 4'd5 : 4'd0);
        flush_next = flush_reg;
        first_next = first_reg;
        user_next  = user_reg;

        if (s_fire) begin
            buf_next = (buf_next & ~({24'd0, 40'hFF_FFFF_FFFF} << {base, 3'b000}))
                     | ({24'd0, in_bytes} << {base, 3'b000});
            if (s.tlast) begin
                flush_next = 1'b1;
            end
            // Only the opening beat of a line carries the line's tuser.
            if (first_reg && (cnt_reg == 4'd0)) begin
                user_next = s.tuser;
            end
        end

        if (m_fire) begin
            first_next = 1'b0;
            if (m_last) begin
                // Line fully drained: drop any padding and rearm for the next line.
                flush_next = 1'b0;
                cnt_next   = 4'd0;
                buf_next   = '0;
                first_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_reg   <= '0;
            cnt_reg   <= 4'd0;
            flush_reg <= 1'b0;
            first_reg <= 1'b1;
            user_reg  <= '0;
        end else begin
            buf_reg   <= buf_next;
            cnt_reg   <= cnt_next;
            flush_reg <= flush_next;
            first_reg <= first_next;
            user_reg  <= user_next;
        end
    end

endmodule
